// File: rtl/pat_pkg.sv
// Shared types and sizing for the serial pattern buffer controller.
package pat_pkg;

   localparam int PAT_BUF_WIDTH = 8;
   localparam int PAT_BUF_SIZE  = 32;
   localparam int PAT_PTR_W     = 5;
   localparam int PAT_SHIFTS    = PAT_BUF_WIDTH * PAT_BUF_SIZE;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_LD_WAIT  = 2'd1,
      ST_LD_SHIFT = 2'd2,
      ST_PLAY     = 2'd3
   } pat_seq_state_t;

endpackage

// File: rtl/pat_serializer.sv
// Byte-to-serial shifter: after a load it drives ssel/sin MSB-first for
// exactly W cycles and flags the final bit.
module pat_serializer #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] data_i,
   output logic         ssel_o,
   output logic         sin_o,
   output logic         last_bit_o
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;

   logic [W-1:0]  shreg_q, shreg_d;
   logic [CW-1:0] bit_cnt_q, bit_cnt_d;
   logic          active_q, active_d;

   assign last_bit_o = active_q && (bit_cnt_q == CW'(W - 1));
   assign ssel_o     = active_q;
   // Shifted-out positions refill with zeros, so sin idles low between bytes.
   assign sin_o      = shreg_q[W-1];

   always_comb begin
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      active_d  = active_q;
      if (load_i) begin
         shreg_d   = data_i;
         bit_cnt_d = '0;
         active_d  = 1'b1;
      end else if (active_q) begin
         shreg_d   = {shreg_q[W-2:0], 1'b0};
         bit_cnt_d = bit_cnt_q + 1'b1;
         if (last_bit_o) active_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         active_q  <= 1'b0;
      end else begin
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         active_q  <= active_d;
      end
   end

endmodule

// File: rtl/pattern_sequencer.sv
// Pattern buffer controller: serial loader for a BUF_SIZE-field pattern and
// a field-pointer player with programmable range, dwell and looping.
module pattern_sequencer
   import pat_pkg::*;
#(
   parameter int BUF_WIDTH = PAT_BUF_WIDTH,
   parameter int BUF_SIZE  = PAT_BUF_SIZE,
   parameter int PTR_W     = PAT_PTR_W,
   parameter int HOLD_W    = 8
) (
   input  logic                 sclk,
   input  logic                 rst,
   input  logic                 load_start,
   input  logic [BUF_WIDTH-1:0] load_data,
   input  logic                 load_valid,
   output logic                 load_ready,
   input  logic                 play_start,
   input  logic                 play_stop,
   input  logic [PTR_W-1:0]     first_field,
   input  logic [PTR_W-1:0]     last_field,
   input  logic [HOLD_W-1:0]    hold_cycles,
   input  logic                 loop_en,
   output logic                 ssel,
   output logic                 sin,
   output logic [PTR_W-1:0]     fieldp,
   input  logic [BUF_WIDTH-1:0] field_byte,
   output logic [BUF_WIDTH-1:0] field_out,
   output logic                 field_valid,
   output logic                 loaded,
   output logic                 busy,
   output logic                 done
);

   pat_seq_state_t state_q, state_d;

   logic [PTR_W-1:0]     byte_cnt_q, byte_cnt_d;
   logic                 loaded_q, loaded_d;
   logic [PTR_W-1:0]     fieldp_q, fieldp_d;
   logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
   logic [PTR_W-1:0]     first_q, first_d;
   logic [PTR_W-1:0]     last_q, last_d;
   logic [HOLD_W-1:0]    hold_q, hold_d;
   logic                 loop_q, loop_d;
   logic                 new_q, new_d;
   logic [BUF_WIDTH-1:0] field_out_q, field_out_d;
   logic                 field_valid_q, field_valid_d;
   logic                 done_q, done_d;
   logic                 load_ready_q, busy_q;
   logic                 ser_load, ser_last;

   pat_serializer #(.W(BUF_WIDTH)) u_ser (
      .clk_i      (sclk),
      .rst_i      (rst),
      .load_i     (ser_load),
      .data_i     (load_data),
      .ssel_o     (ssel),
      .sin_o      (sin),
      .last_bit_o (ser_last)
   );

   assign load_ready  = load_ready_q;
   assign fieldp      = fieldp_q;
   assign field_out   = field_out_q;
   assign field_valid = field_valid_q;
   assign loaded      = loaded_q;
   assign busy        = busy_q;
   assign done        = done_q;

   always_comb begin
      state_d       = state_q;
      byte_cnt_d    = byte_cnt_q;
      loaded_d      = loaded_q;
      fieldp_d      = fieldp_q;
      hold_cnt_d    = hold_cnt_q;
      first_d       = first_q;
      last_d        = last_q;
      hold_d        = hold_q;
      loop_d        = loop_q;
      new_d         = 1'b0;
      field_out_d   = field_out_q;
      field_valid_d = 1'b0;
      done_d        = 1'b0;
      ser_load      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (load_start) begin
               state_d    = ST_LD_WAIT;
               loaded_d   = 1'b0;
               byte_cnt_d = '0;
            end else if (play_start && loaded_q) begin
               state_d    = ST_PLAY;
               first_d    = first_field;
               last_d     = last_field;
               hold_d     = hold_cycles;
               loop_d     = loop_en;
               fieldp_d   = first_field;
               hold_cnt_d = hold_cycles;
               new_d      = 1'b1;
            end
         end
         ST_LD_WAIT: begin
            if (load_valid) begin
               ser_load = 1'b1;
               state_d  = ST_LD_SHIFT;
            end
         end
         ST_LD_SHIFT: begin
            if (ser_last) begin
               if (byte_cnt_q == PTR_W'(BUF_SIZE - 1)) begin
                  state_d  = ST_IDLE;
                  loaded_d = 1'b1;
               end else begin
                  byte_cnt_d = byte_cnt_q + 1'b1;
                  state_d    = ST_LD_WAIT;
               end
            end
         end
         ST_PLAY: begin
            // A stop on the first cycle of a dwell suppresses that capture too.
            if (play_stop) begin
               state_d = ST_IDLE;
            end else begin
               if (new_q) begin
                  field_out_d   = field_byte;
                  field_valid_d = 1'b1;
               end
               if (hold_cnt_q != '0) begin
                  hold_cnt_d = hold_cnt_q - 1'b1;
               end else if (fieldp_q == last_q) begin
                  if (loop_q) begin
                     fieldp_d   = first_q;
                     hold_cnt_d = hold_q;
                     new_d      = 1'b1;
                  end else begin
                     done_d  = 1'b1;
                     state_d = ST_IDLE;
                  end
               end else begin
                  fieldp_d   = fieldp_q + 1'b1;
                  hold_cnt_d = hold_q;
                  new_d      = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge sclk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge sclk) begin
      if (rst) begin
         byte_cnt_q    <= '0;
         loaded_q      <= 1'b0;
         fieldp_q      <= '0;
         hold_cnt_q    <= '0;
         first_q       <= '0;
         last_q        <= '0;
         hold_q        <= '0;
         loop_q        <= 1'b0;
         new_q         <= 1'b0;
         field_out_q   <= '0;
         field_valid_q <= 1'b0;
         done_q        <= 1'b0;
         load_ready_q  <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         byte_cnt_q    <= byte_cnt_d;
         loaded_q      <= loaded_d;
         fieldp_q      <= fieldp_d;
         hold_cnt_q    <= hold_cnt_d;
         first_q       <= first_d;
         last_q        <= last_d;
         hold_q        <= hold_d;
         loop_q        <= loop_d;
         new_q         <= new_d;
         field_out_q   <= field_out_d;
         field_valid_q <= field_valid_d;
         done_q        <= done_d;
         load_ready_q  <= (state_d == ST_LD_WAIT);
         busy_q        <= (state_d != ST_IDLE);
      end
   end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer with a behavioural serial pattern buffer.
module tb_pattern_sequencer;
   import pat_pkg::*;

   localparam int W  = 8;
   localparam int N  = 32;
   localparam int PW = 5;
   localparam int HW = 8;

   logic          sclk = 1'b0;
   logic          rst = 1'b1;
   logic          load_start = 1'b0;
   logic [W-1:0]  load_data = '0;
   logic          load_valid = 1'b0;
   logic          load_ready;
   logic          play_start = 1'b0;
   logic          play_stop = 1'b0;
   logic [PW-1:0] first_field = '0;
   logic [PW-1:0] last_field = '0;
   logic [HW-1:0] hold_cycles = '0;
   logic          loop_en = 1'b0;
   logic          ssel, sin;
   logic [PW-1:0] fieldp;
   logic [W-1:0]  field_byte;
   logic [W-1:0]  field_out;
   logic          field_valid, loaded, busy, done;

   logic [W*N-1:0] pbuf = '0;
   logic [W*N-1:0] exp_buf;
   int cyc = 0, ssel_cnt = 0, viol = 0;
   int pass_cnt = 0, chk_cnt = 0;

   pattern_sequencer #(.BUF_WIDTH(W), .BUF_SIZE(N), .PTR_W(PW), .HOLD_W(HW)) dut (
      .sclk(sclk), .rst(rst), .load_start(load_start), .load_data(load_data),
      .load_valid(load_valid), .load_ready(load_ready), .play_start(play_start),
      .play_stop(play_stop), .first_field(first_field), .last_field(last_field),
      .hold_cycles(hold_cycles), .loop_en(loop_en), .ssel(ssel), .sin(sin),
      .fieldp(fieldp), .field_byte(field_byte), .field_out(field_out),
      .field_valid(field_valid), .loaded(loaded), .busy(busy), .done(done)
   );

   always #5 sclk = ~sclk;

   // Pattern buffer model: serial shift in, field i at bits [8i+7:8i].
   always @(posedge sclk) begin
      if (ssel) pbuf <= {pbuf[W*N-2:0], sin};
      cyc <= cyc + 1;
      if (ssel) ssel_cnt <= ssel_cnt + 1;
      if (ssel && load_ready) viol <= viol + 1;
   end
   assign field_byte = pbuf[fieldp*W +: W];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick;
      @(posedge sclk);
      #1;
   endtask

   task automatic feed_bytes(input int gap, input int nb);
      for (int b = 0; b < nb; b++) begin
         int w;
         w = 0;
         while (load_ready !== 1'b1 && w < 20) begin tick; w++; end
         if (load_ready !== 1'b1) begin
            chk_cnt++;
            $display("FAIL load_ready_timeout byte %0d: load_ready=%b required 1", b, load_ready);
         end
         for (int g = 0; g < gap; g++) begin
            load_valid = 1'b0;
            tick;
            chk_cnt++;
            if (ssel !== 1'b0 || load_ready !== 1'b1)
               $display("FAIL stall_wait byte %0d: ssel=%b load_ready=%b required 0/1", b, ssel, load_ready);
            else pass_cnt++;
         end
         load_valid = 1'b1;
         load_data  = W'(31 - b);
         tick;
         if (gap != 0) load_valid = 1'b0;
      end
      load_valid = 1'b0;
   endtask

   task automatic load_pattern(input int gap, output int lat);
      int c0, s0, w;
      load_start = 1'b1;
      tick;
      load_start = 1'b0;
      c0 = cyc;
      s0 = ssel_cnt;
      chk_cnt++;
      if (load_ready !== 1'b1 || loaded !== 1'b0 || busy !== 1'b1)
         $display("FAIL load_accept: ready/loaded/busy=%b%b%b required 101", load_ready, loaded, busy);
      else pass_cnt++;
      feed_bytes(gap, 32);
      w = 0;
      while (loaded !== 1'b1 && w < 30) begin tick; w++; end
      lat = cyc - c0;
      chk_cnt++;
      if (loaded !== 1'b1 || busy !== 1'b0)
         $display("FAIL load_done: loaded=%b busy=%b required 1/0", loaded, busy);
      else pass_cnt++;
      chk_cnt++;
      if (ssel_cnt - s0 !== 256) $display("FAIL ssel_count: got %0d required 256", ssel_cnt - s0);
      else pass_cnt++;
      chk_cnt++;
      if (pbuf !== exp_buf) $display("FAIL buffer_contents: got %h required %h", pbuf, exp_buf);
      else pass_cnt++;
   endtask

   task automatic start_play(input logic [PW-1:0] f, input logic [PW-1:0] l,
                             input logic [HW-1:0] h, input logic lp);
      first_field = f; last_field = l; hold_cycles = h; loop_en = lp;
      play_start = 1'b1;
      tick;
      play_start = 1'b0;
      chk_cnt++;
      if (busy !== 1'b1 || fieldp !== f)
         $display("FAIL play_accept: busy=%b fieldp=%0d required 1/%0d", busy, fieldp, f);
      else pass_cnt++;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick; tick;
      chk_cnt++;
      if ({ssel, sin, fieldp, field_out, field_valid, load_ready, loaded, busy, done} !== '0)
         $display("FAIL reset_state: ssel=%b sin=%b fieldp=%0d out=%h fv=%b rdy=%b ld=%b busy=%b done=%b required all 0",
                  ssel, sin, fieldp, field_out, field_valid, load_ready, loaded, busy, done);
      else pass_cnt++;
      rst = 1'b0;
      tick;
   endtask

   task automatic test_play_unloaded;
      start_play_reject();
   endtask

   task automatic start_play_reject;
      first_field = 5'd3; last_field = 5'd4; hold_cycles = '0; loop_en = 1'b0;
      play_start = 1'b1;
      tick;
      play_start = 1'b0;
      chk_cnt++;
      if (busy !== 1'b0 || fieldp !== 5'd0 || loaded !== 1'b0)
         $display("FAIL play_unloaded: busy=%b fieldp=%0d required 0/0", busy, fieldp);
      else pass_cnt++;
   endtask

   task automatic test_load_play;
      int lat;
      load_pattern(0, lat);
      chk_cnt++;
      if (lat !== 288) $display("FAIL load_latency: got %0d required 288", lat);
      else pass_cnt++;
      start_play(5'd0, 5'd31, 8'd0, 1'b0);
      for (int k = 0; k < 32; k++) begin
         tick;
         chk_cnt++;
         if (field_valid !== 1'b1 || field_out !== W'(k))
            $display("FAIL play_field %0d: valid=%b out=%h required 1/%h", k, field_valid, field_out, W'(k));
         else pass_cnt++;
         chk_cnt++;
         if (done !== (k == 31) || busy !== (k != 31))
            $display("FAIL play_done %0d: done=%b busy=%b", k, done, busy);
         else pass_cnt++;
      end
      tick;
      chk_cnt++;
      if (done !== 1'b0 || field_valid !== 1'b0 || loaded !== 1'b1)
         $display("FAIL play_after: done=%b fv=%b loaded=%b required 0/0/1", done, field_valid, loaded);
      else pass_cnt++;
   endtask

   task automatic test_hold_loop;
      start_play(5'd5, 5'd7, 8'd2, 1'b1);
      first_field = 5'd0;
      for (int t = 1; t <= 15; t++) begin
         if (t == 8) load_start = 1'b1;
         tick;
         load_start = 1'b0;
         chk_cnt++;
         if (field_valid !== (t % 3 == 1))
            $display("FAIL hold_valid t=%0d: got %b required %b", t, field_valid, (t % 3 == 1));
         else pass_cnt++;
         if (t % 3 == 1) begin
            chk_cnt++;
            if (field_out !== W'(5 + ((t - 1) / 3) % 3))
               $display("FAIL hold_field t=%0d: got %h required %h", t, field_out, W'(5 + ((t - 1) / 3) % 3));
            else pass_cnt++;
         end
         chk_cnt++;
         if (busy !== 1'b1 || done !== 1'b0 || loaded !== 1'b1 || load_ready !== 1'b0)
            $display("FAIL hold_status t=%0d: busy=%b done=%b loaded=%b ready=%b", t, busy, done, loaded, load_ready);
         else pass_cnt++;
      end
      play_stop = 1'b1;
      tick;
      play_stop = 1'b0;
      chk_cnt++;
      if (busy !== 1'b0 || done !== 1'b0 || field_valid !== 1'b0)
         $display("FAIL stop: busy=%b done=%b fv=%b required 0/0/0", busy, done, field_valid);
      else pass_cnt++;
      for (int t = 0; t < 5; t++) begin
         tick;
         chk_cnt++;
         if (done !== 1'b0 || field_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL after_stop t=%0d: done=%b fv=%b busy=%b", t, done, field_valid, busy);
         else pass_cnt++;
      end
   endtask

   task automatic test_wrap;
      logic [W-1:0] ev [4];
      ev[0] = 8'h1E; ev[1] = 8'h1F; ev[2] = 8'h00; ev[3] = 8'h01;
      start_play(5'd30, 5'd1, 8'd0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         tick;
         chk_cnt++;
         if (field_valid !== 1'b1 || field_out !== ev[k] || done !== (k == 3))
            $display("FAIL wrap %0d: fv=%b out=%h done=%b required 1/%h/%b", k, field_valid, field_out, done, ev[k], (k == 3));
         else pass_cnt++;
      end
   endtask

   task automatic test_simultaneous;
      first_field = 5'd0; last_field = 5'd3;
      load_start = 1'b1;
      play_start = 1'b1;
      tick;
      load_start = 1'b0;
      play_start = 1'b0;
      chk_cnt++;
      if (load_ready !== 1'b1 || loaded !== 1'b0 || busy !== 1'b1)
         $display("FAIL simultaneous: ready=%b loaded=%b busy=%b required 1/0/1", load_ready, loaded, busy);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid;
      int s0;
      s0 = ssel_cnt;
      feed_bytes(0, 13);
      tick; tick; tick; tick;
      chk_cnt++;
      if (ssel_cnt - s0 !== 100 || ssel !== 1'b1)
         $display("FAIL mid_shifts: got %0d ssel=%b required 100/1", ssel_cnt - s0, ssel);
      else pass_cnt++;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk_cnt++;
      if ({ssel, sin, fieldp, field_out, field_valid, load_ready, loaded, busy, done} !== '0)
         $display("FAIL mid_reset: ssel=%b sin=%b fieldp=%0d out=%h fv=%b rdy=%b ld=%b busy=%b done=%b required all 0",
                  ssel, sin, fieldp, field_out, field_valid, load_ready, loaded, busy, done);
      else pass_cnt++;
      tick;
      chk_cnt++;
      if (busy !== 1'b0 || ssel !== 1'b0) $display("FAIL mid_idle: busy=%b ssel=%b required 0/0", busy, ssel);
      else pass_cnt++;
   endtask

   task automatic test_stall;
      int lat;
      load_pattern(3, lat);
      chk_cnt++;
      if (lat !== 384) $display("FAIL stall_latency: got %0d required 384", lat);
      else pass_cnt++;
      chk_cnt++;
      if (viol !== 0) $display("FAIL ssel_in_wait: got %0d required 0", viol);
      else pass_cnt++;
      start_play(5'd31, 5'd31, 8'd0, 1'b0);
      tick;
      chk_cnt++;
      if (field_valid !== 1'b1 || field_out !== 8'h1F || done !== 1'b1 || busy !== 1'b0)
         $display("FAIL single_field: fv=%b out=%h done=%b busy=%b required 1/1f/1/0", field_valid, field_out, done, busy);
      else pass_cnt++;
   endtask

   initial begin
      for (int i = 0; i < N; i++) exp_buf[i*W +: W] = W'(i);
      test_reset;
      test_play_unloaded;
      test_load_play;
      test_hold_loop;
      test_wrap;
      test_simultaneous;
      test_reset_mid;
      test_stall;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/pattern_sequencer.md
# pattern_sequencer

Controller for the serial pattern buffer. Loads the buffer with a 32-byte pattern by converting a byte stream into the buffer's serial `ssel`/`sin` shift protocol. Once loaded, it steps the buffer's field pointer `fieldp` through a programmable field range with a programmable dwell per field, and registers each selected `field_byte` for the downstream pattern engine. It sits between the configuration/host port and the pattern buffer.

## Interface
Parameters:
- `BUF_WIDTH`, 8: buffer word width (bits per field).
- `BUF_SIZE`, 32: number of fields.
- `PTR_W`, 5: field pointer width; `2**PTR_W == BUF_SIZE`.
- `HOLD_W`, 8: dwell counter width.

Ports (one clock; reset is synchronous and active-high):
- `sclk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous active-high reset.
- `load_start`  in  1  begin loading a new pattern; honoured only in IDLE.
- `load_data`  in  BUF_WIDTH  pattern byte.
- `load_valid`  in  1  `load_data` valid.
- `load_ready`  out  1  controller accepts a byte this cycle.
- `play_start`  in  1  begin playback; honoured only in IDLE with `loaded`=1.
- `play_stop`  in  1  abort playback.
- `first_field`, `last_field`  in  PTR_W  playback range, sampled on an accepted `play_start`.
- `hold_cycles`  in  HOLD_W  dwell per field minus one, sampled on an accepted `play_start`.
- `loop_en`  in  1  restart at `first_field` after `last_field`; sampled on an accepted `play_start`.
- `ssel`  out  1  buffer shift enable.
- `sin`  out  1  buffer serial data.
- `fieldp`  out  PTR_W  buffer field pointer.
- `field_byte`  in  BUF_WIDTH  selected field from the buffer (combinational from `fieldp`).
- `field_out`  out  BUF_WIDTH  registered field value.
- `field_valid`  out  1  one-cycle pulse: new `field_out`.
- `loaded`  out  1  a complete pattern is in the buffer.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse at the natural end of a non-looping playback.

## Operation
- **States:** IDLE, LD_WAIT, LD_SHIFT, PLAY.
- **IDLE → LD_WAIT** on `load_start`. Clears `loaded` and `byte_cnt`.
- **LD_WAIT:**
  - `load_ready`=1.
  - On `load_valid`, the byte is latched into the shift register and the state moves to LD_SHIFT with `bit_cnt`=0.
  - Waits indefinitely otherwise.
- **LD_SHIFT:**
  - `ssel`=1 and `sin`=shreg MSB for exactly 8 consecutive cycles.
  - The shift register moves left each cycle.
  - After bit 7: if `byte_cnt`==BUF_SIZE-1, go to IDLE and set `loaded`=1; else increment `byte_cnt` and return to LD_WAIT.
- **Byte ordering:** bytes are sent MSB-first. The first byte accepted ends up in field BUF_SIZE-1 and the last byte in field 0. Total is exactly 256 shift edges per load.
- **IDLE → PLAY** on `play_start` with `loaded`=1. Latches the range, hold and loop settings, sets `fieldp`=`first_field`, and sets `hold_cnt`=`hold_cycles`.
- **PLAY:**
  - Each field is held for `hold_cycles`+1 cycles.
  - When `hold_cnt`==0, `fieldp` advances modulo BUF_SIZE (31 wraps to 0, so `first_field` > `last_field` is legal and wraps).
  - At the end of the `last_field` dwell: if `loop_en`, reload `first_field`; else pulse `done` and go to IDLE.
  - `first_field`==`last_field` plays a single field.
- **Capture:** `field_out` <= `field_byte` on the first cycle of every dwell, including repeats of the same field when looping.
- **Stop:** `play_stop` in PLAY goes to IDLE at the next edge. No `done` and no further `field_valid`.
- **Priority:** `play_stop` takes priority over the dwell end.
- **Ignored requests:**
  - `load_start` and `play_start` are ignored while `busy`.
  - `play_start` is ignored when `loaded`=0.
  - `load_start` and `play_start` together in IDLE: `load_start` wins.
- **Reset:**
  - Outputs reset to: `ssel`=0, `sin`=0, `fieldp`=0, `field_out`=0, `field_valid`=0, `load_ready`=0, `loaded`=0, `busy`=0, `done`=0; state is IDLE.
  - Reset mid-load leaves the buffer contents undefined and `loaded`=0.
  - Reset mid-play stops the sequence.

## Timing
- All outputs are registered.
- `load_ready` rises the cycle after an accepted `load_start`.
- Each byte costs at least 9 cycles: 1 accept cycle plus 8 shift cycles. Minimum load time is 32×9 = 288 cycles after `load_start` is accepted. `loaded` rises at the edge ending the 256th `ssel` cycle.
- `fieldp` is valid the cycle after `play_start` is accepted. `field_out` and `field_valid` follow one cycle after each `fieldp` update.
- Field period is `hold_cycles`+1 cycles.
- `done` coincides with `busy` falling.

## Structure
- **Package `pat_pkg`:** state enum `pat_seq_state_t`, and localparams `PAT_BUF_WIDTH`, `PAT_BUF_SIZE`, `PAT_PTR_W`, `PAT_SHIFTS` (=256).
- **Sub-module `pat_serializer`:** byte-to-serial shifter with its `bit_cnt`. It takes a byte in, drives `sin`/`ssel`, and asserts `last_bit`. The sequencer owns the FSM, `byte_cnt` and the playback counters.

## Test plan
1. **Load then play.** Load bytes 0x1F..0x00 (first byte sent 0x1F, last 0x00), with `load_valid` held high; patternbuf model attached.
   - Exactly 256 `ssel` cycles; `loaded`=1.
   - Playback 0→31, hold 0 → `field_out` = 0x00..0x1F on consecutive cycles, then `done`.
2. **Source stalls.** `load_valid` gaps of 3 cycles between bytes → identical buffer contents; `ssel` never high in LD_WAIT.
3. **Hold and loop.** `hold_cycles`=2, range 5→7, `loop_en`=1.
   - `field_valid` every 3 cycles; fields 5,6,7,5,6,…
   - `play_stop` → `busy` drops next edge; no `done`.
4. **Wrap range.** Range 30→1 → field order 30,31,0,1, then `done`.
5. **Rejected and simultaneous requests.**
   - `play_start` with `loaded`=0 → ignored.
   - `load_start` during PLAY → ignored.
   - `load_start` and `play_start` together in IDLE → load begins.
6. **Reset mid-operation.**
   - `rst` after 100 shifts → all outputs at reset values next cycle; `loaded`=0; a fresh load completes correctly.
